// File: rtl/stft_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stft_frame_ctrl_pkg
//   Shared geometry of the STFT sample bank. The bank, this controller and the
//   FFT/window stage all import these values so they agree on slot count,
//   frame length and hop.
//   Contents:
//     STFT_DEPTH      register slots in the circular bank
//     STFT_FRAME_LEN  samples per STFT frame
//     STFT_HOP        samples retired per frame handoff
//     STFT_AW         slot index width (clog2 of STFT_DEPTH)
//     STFT_FCW        frame counter width
//   Legal geometry: 1 <= HOP <= FRAME_LEN <= DEPTH <= 2**AW.
// -----------------------------------------------------------------------------
package stft_frame_ctrl_pkg;

   localparam int unsigned STFT_DEPTH     = 16;
   localparam int unsigned STFT_FRAME_LEN = 8;
   localparam int unsigned STFT_HOP       = 4;
   localparam int unsigned STFT_AW        = 4;
   localparam int unsigned STFT_FCW       = 16;

endpackage

// File: rtl/stft_frame_ctrl_ptr_wrap_add.sv
// -----------------------------------------------------------------------------
// ptr_wrap_add
//   Combinational (ptr + inc) mod DEPTH for circular slot pointers. DEPTH need
//   not be a power of two, so the wrap is an explicit compare-and-subtract.
//   Valid for ptr < DEPTH and inc <= DEPTH (one subtraction is then enough).
//   Ports:
//     i_ptr  [AW-1:0]  current slot index
//     i_inc  [AW:0]    increment, 0..DEPTH
//     o_sum  [AW-1:0]  wrapped result
// -----------------------------------------------------------------------------
module ptr_wrap_add #(
   parameter int unsigned AW    = 4,
   parameter int unsigned DEPTH = 16
) (
   input  logic [AW-1:0] i_ptr,
   input  logic [AW:0]   i_inc,
   output logic [AW-1:0] o_sum
);

   localparam logic [AW+1:0] LP_DEPTH = (AW+2)'(DEPTH);

   logic [AW+1:0] w_raw;

   assign w_raw = {2'b00, i_ptr} + {1'b0, i_inc};
   assign o_sum = (w_raw >= LP_DEPTH) ? AW'(w_raw - LP_DEPTH) : AW'(w_raw);

endmodule

// File: rtl/stft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// stft_frame_ctrl
//   Sequencer for the circular sample register bank in front of the STFT FFT.
//   Each accepted sample gets a one-hot load enable into the next slot; once
//   FRAME_LEN samples are held a frame is offered (base index of its oldest
//   sample) over valid/ready, and each handoff retires HOP samples so that
//   successive frames overlap.
//   Ports:
//     iCLK, iRSTn        clock (rising) / asynchronous active-low reset
//     iRUN               1 = accept samples, 0 = hold (a valid frame is still offered)
//     iCLR               synchronous clear, wins over accept and take
//     iVALID / oREADY    sample handshake (oREADY combinational)
//     oEN [DEPTH]        one-hot slot load enable, zero when nothing is accepted
//     oFRAME_VALID       frame available (count >= FRAME_LEN)
//     iFRAME_READY       downstream takes the frame this cycle
//     oFRAME_BASE [AW]   slot of the oldest sample in the frame
//     oCOUNT [AW+1]      samples held, 0..DEPTH
//     oFRAME_CNT [FCW]   frames handed off, wraps
//     oOVERFLOW          sticky: a sample arrived while the bank was full
// -----------------------------------------------------------------------------
module stft_frame_ctrl
   import stft_frame_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH     = STFT_DEPTH,
   parameter int unsigned FRAME_LEN = STFT_FRAME_LEN,
   parameter int unsigned HOP       = STFT_HOP,
   parameter int unsigned AW        = STFT_AW,
   parameter int unsigned FCW       = STFT_FCW
) (
   input  logic             iCLK,
   input  logic             iRSTn,
   input  logic             iRUN,
   input  logic             iCLR,
   input  logic             iVALID,
   output logic             oREADY,
   output logic [DEPTH-1:0] oEN,
   output logic             oFRAME_VALID,
   input  logic             iFRAME_READY,
   output logic [AW-1:0]    oFRAME_BASE,
   output logic [AW:0]      oCOUNT,
   output logic [FCW-1:0]   oFRAME_CNT,
   output logic             oOVERFLOW
);

   localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0] LP_FLEN  = (AW+1)'(FRAME_LEN);
   localparam logic [AW:0] LP_HOP   = (AW+1)'(HOP);
   localparam logic [AW:0] LP_ONE   = (AW+1)'(1);

   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_base;
   logic [AW:0]    r_count;
   logic [FCW-1:0] r_fcnt;
   logic           r_ovf;

   logic           w_full;
   logic           w_ready;
   logic           w_accept;
   logic           w_fvalid;
   logic           w_take;
   logic           w_drop;
   logic [AW-1:0]  w_wptr_nxt;
   logic [AW-1:0]  w_base_nxt;
   logic [AW:0]    w_count_nxt;

   assign w_full   = (r_count == LP_DEPTH);
   assign w_ready  = iRUN & ~iCLR & ~w_full;
   assign w_accept = iVALID & w_ready;
   assign w_fvalid = (r_count >= LP_FLEN);
   // Take is independent of iRUN: a frame already offered can drain while paused.
   assign w_take   = w_fvalid & iFRAME_READY & ~iCLR;
   assign w_drop   = iVALID & iRUN & ~iCLR & w_full;

   // Take only fires with count >= FRAME_LEN >= HOP, so this never underflows.
   // The sample accepted this cycle is added on top; it is not part of the
   // frame being retired.
   assign w_count_nxt = r_count + (w_accept ? LP_ONE : '0) - (w_take ? LP_HOP : '0);

   ptr_wrap_add #(.AW(AW), .DEPTH(DEPTH)) u_wptr_add (
      .i_ptr (r_wptr),
      .i_inc (LP_ONE),
      .o_sum (w_wptr_nxt)
   );

   ptr_wrap_add #(.AW(AW), .DEPTH(DEPTH)) u_base_add (
      .i_ptr (r_base),
      .i_inc (LP_HOP),
      .o_sum (w_base_nxt)
   );

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         r_wptr  <= '0;
         r_base  <= '0;
         r_count <= '0;
         r_fcnt  <= '0;
         r_ovf   <= 1'b0;
      end else if (iCLR) begin
         r_wptr  <= '0;
         r_base  <= '0;
         r_count <= '0;
         r_fcnt  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_accept) r_wptr <= w_wptr_nxt;
         if (w_take) begin
            r_base <= w_base_nxt;
            r_fcnt <= r_fcnt + 1'b1;
         end
         r_count <= w_count_nxt;
         if (w_drop) r_ovf <= 1'b1;
      end
   end

   // Zero-latency enable: the bank slot captures on the same edge as the accept.
   always_comb begin
      oEN = '0;
      if (w_accept) oEN[r_wptr] = 1'b1;
   end

   assign oREADY       = w_ready;
   assign oFRAME_VALID = w_fvalid;
   assign oFRAME_BASE  = r_base;
   assign oCOUNT       = r_count;
   assign oFRAME_CNT   = r_fcnt;
   assign oOVERFLOW    = r_ovf;

endmodule

// File: tb/tb_stft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stft_frame_ctrl
//   Directed bench for stft_frame_ctrl (DEPTH=16, FRAME_LEN=8, HOP=4).
//   A small reference model tracks wptr/base/count/frame count/overflow and is
//   compared every cycle; hand-computed literals pin the key scenario points.
// -----------------------------------------------------------------------------
module tb_stft_frame_ctrl;

   logic        iCLK = 1'b0;
   logic        iRSTn;
   logic        iRUN;
   logic        iCLR;
   logic        iVALID;
   logic        oREADY;
   logic [15:0] oEN;
   logic        oFRAME_VALID;
   logic        iFRAME_READY;
   logic [3:0]  oFRAME_BASE;
   logic [4:0]  oCOUNT;
   logic [15:0] oFRAME_CNT;
   logic        oOVERFLOW;

   int total = 0;
   int bad   = 0;

   int m_wptr, m_base, m_cnt, m_fcnt;
   bit m_ovf;

   stft_frame_ctrl dut (
      .iCLK         (iCLK),
      .iRSTn        (iRSTn),
      .iRUN         (iRUN),
      .iCLR         (iCLR),
      .iVALID       (iVALID),
      .oREADY       (oREADY),
      .oEN          (oEN),
      .oFRAME_VALID (oFRAME_VALID),
      .iFRAME_READY (iFRAME_READY),
      .oFRAME_BASE  (oFRAME_BASE),
      .oCOUNT       (oCOUNT),
      .oFRAME_CNT   (oFRAME_CNT),
      .oOVERFLOW    (oOVERFLOW)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wptr = 0; m_base = 0; m_cnt = 0; m_fcnt = 0; m_ovf = 0;
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, ".count"},  32'(oCOUNT),       32'(m_cnt));
      chk({tag, ".fvalid"}, 32'(oFRAME_VALID), 32'(m_cnt >= 8));
      chk({tag, ".base"},   32'(oFRAME_BASE),  32'(m_base));
      chk({tag, ".fcnt"},   32'(oFRAME_CNT),   32'(m_fcnt & 16'hFFFF));
      chk({tag, ".ovf"},    32'(oOVERFLOW),    32'(m_ovf));
   endtask

   // One clock: drive inputs, check combinational outputs, clock, check state.
   task automatic cyc(input bit v, input bit fr, input bit run, input bit clr, input string tag);
      bit          rdy, acc, take;
      logic [15:0] en;
      iVALID = v; iFRAME_READY = fr; iRUN = run; iCLR = clr;
      #1;
      rdy  = run && !clr && (m_cnt < 16);
      acc  = v && rdy;
      take = (m_cnt >= 8) && fr && !clr;
      en   = acc ? 16'(1 << m_wptr) : 16'h0000;
      chk({tag, ".ready"}, 32'(oREADY), 32'(rdy));
      chk({tag, ".en"},    32'(oEN),    32'(en));
      @(posedge iCLK);
      if (clr) model_reset();
      else begin
         if (v && run && m_cnt == 16) m_ovf = 1;
         if (acc)  m_wptr = (m_wptr + 1) % 16;
         if (take) begin m_base = (m_base + 4) % 16; m_fcnt++; end
         m_cnt = m_cnt + (acc ? 1 : 0) - (take ? 4 : 0);
      end
      #1;
      chk_regs(tag);
   endtask

   initial begin
      iRSTn = 1'b0; iRUN = 1'b0; iCLR = 1'b0; iVALID = 1'b0; iFRAME_READY = 1'b0;
      model_reset();
      repeat (2) @(posedge iCLK);
      #1;
      // reset state
      chk("rst.en",     32'(oEN),          32'h0);
      chk("rst.fvalid", 32'(oFRAME_VALID), 32'h0);
      chk("rst.base",   32'(oFRAME_BASE),  32'h0);
      chk("rst.count",  32'(oCOUNT),       32'h0);
      chk("rst.fcnt",   32'(oFRAME_CNT),   32'h0);
      chk("rst.ovf",    32'(oOVERFLOW),    32'h0);
      iRSTn = 1'b1;

      // 1: eight accepts fill the first frame, enables walk 0x0001..0x0080
      for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0, "t1");
      chk("t1.count8", 32'(oCOUNT),       32'd8);
      chk("t1.fvalid", 32'(oFRAME_VALID), 32'd1);
      chk("t1.base0",  32'(oFRAME_BASE),  32'd0);

      // 2: single take retires HOP samples
      cyc(0, 1, 1, 0, "t2");
      chk("t2.base4",  32'(oFRAME_BASE),  32'd4);
      chk("t2.count4", 32'(oCOUNT),       32'd4);
      chk("t2.fcnt1",  32'(oFRAME_CNT),   32'd1);
      chk("t2.fvalid", 32'(oFRAME_VALID), 32'd0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, "t2f");
      chk("t2.still0", 32'(oFRAME_VALID), 32'd0);
      cyc(1, 0, 1, 0, "t2f");
      chk("t2.fv_back", 32'(oFRAME_VALID), 32'd1);

      // 3: accept and take in the same cycle at count=8 (wptr=12, base=4)
      iVALID = 1'b1; iFRAME_READY = 1'b1; #1;
      chk("t3.en12", 32'(oEN), 32'h1000);
      cyc(1, 1, 1, 0, "t3");
      chk("t3.count5", 32'(oCOUNT),      32'd5);
      chk("t3.base8",  32'(oFRAME_BASE), 32'd8);
      iVALID = 1'b1; iFRAME_READY = 1'b0; #1;
      chk("t3.en13", 32'(oEN), 32'h2000);

      // 4: no takes, stream 15 samples: 11 fit, 4 are dropped
      for (int i = 0; i < 15; i++) cyc(1, 0, 1, 0, "t4");
      chk("t4.full",  32'(oCOUNT),    32'd16);
      chk("t4.nrdy",  32'(oREADY),    32'd0);
      chk("t4.ovf",   32'(oOVERFLOW), 32'd1);
      chk("t4.base_hold", 32'(oFRAME_BASE), 32'd8);

      // 5: continuous input with continuous takes, base and wptr both wrap
      for (int i = 0; i < 24; i++) cyc(1, 1, 1, 0, "t5");
      chk("t5.ovf_sticky", 32'(oOVERFLOW), 32'd1);

      // 6a: synchronous clear from a full-ish state, then clear mid-frame
      cyc(0, 0, 1, 1, "t6clr");
      chk("t6.count0", 32'(oCOUNT),     32'd0);
      chk("t6.ovf0",   32'(oOVERFLOW),  32'd0);
      chk("t6.fcnt0",  32'(oFRAME_CNT), 32'd0);
      for (int i = 0; i < 6; i++) cyc(1, 0, 1, 0, "t6fill");
      chk("t6.count6", 32'(oCOUNT), 32'd6);
      cyc(1, 1, 1, 1, "t6clr2");
      chk("t6.count0b", 32'(oCOUNT), 32'd0);

      // iRUN=0: valid is ignored (no overflow), a valid frame still drains
      for (int i = 0; i < 16; i++) cyc(1, 0, 1, 0, "t7fill");
      cyc(1, 0, 0, 0, "t7idle");
      chk("t7.no_ovf",  32'(oOVERFLOW), 32'd0);
      chk("t7.hold16",  32'(oCOUNT),    32'd16);
      cyc(0, 1, 0, 0, "t7take");
      chk("t7.count12", 32'(oCOUNT),     32'd12);
      chk("t7.fcnt1",   32'(oFRAME_CNT), 32'd1);
      chk("t7.base4",   32'(oFRAME_BASE), 32'd4);

      // 6b: asynchronous reset mid-cycle discards everything
      cyc(1, 0, 1, 0, "t8pre");
      iVALID = 1'b0; iFRAME_READY = 1'b0;
      #2 iRSTn = 1'b0;
      #1;
      model_reset();
      chk("t8.count0", 32'(oCOUNT),       32'd0);
      chk("t8.fcnt0",  32'(oFRAME_CNT),   32'd0);
      chk("t8.en0",    32'(oEN),          32'd0);
      chk("t8.fv0",    32'(oFRAME_VALID), 32'd0);
      @(posedge iCLK);
      #1 iRSTn = 1'b1;
      cyc(1, 0, 1, 0, "t8post");
      chk("t8.count1", 32'(oCOUNT), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
